// File: rtl/key_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// key_pkg : shared FSM encoding and 50 MHz timing defaults for the key path
// Revision: 1.0
// ----------------------------------------------------------------------------
package key_pkg;

    localparam int unsigned LONG_CYC_DEF = 50_000_000;
    localparam int unsigned DBL_CYC_DEF  = 15_000_000;
    localparam int unsigned RPT_CYC_DEF  = 5_000_000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_WAIT2  = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_LONG   = 3'd4
    } fsm_state_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_evt_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// key_evt_timer : saturating up-counter with clear, reload and count enable
// Revision: 1.0
// ----------------------------------------------------------------------------
module key_evt_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic             i_reload,
    input  logic [WIDTH-1:0] i_reload_val,
    output logic [WIDTH-1:0] o_count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_count <= '0;
        end else if (i_clear) begin
            o_count <= '0;
        end else if (i_reload) begin
            o_count <= i_reload_val;
        end else if (i_enable && (o_count != {WIDTH{1'b1}})) begin
            o_count <= o_count + WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/key_event.sv
`default_nettype none
// ----------------------------------------------------------------------------
// key_event : classifies a debounced key into single/double/long/repeat pulses
// Revision: 1.0
// ----------------------------------------------------------------------------
module key_event
    import key_pkg::*;
#(
    parameter int unsigned LONG_CYC = LONG_CYC_DEF,
    parameter int unsigned DBL_CYC  = DBL_CYC_DEF,
    parameter int unsigned RPT_CYC  = RPT_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_state,
    output logic pressed,
    output logic evt_single,
    output logic evt_double,
    output logic evt_long,
    output logic evt_repeat,
    output logic busy
);

    localparam int unsigned c_max_cyc = max3(LONG_CYC, DBL_CYC, RPT_CYC);
    localparam int unsigned c_tw      = (c_max_cyc > 1) ? $clog2(c_max_cyc) : 1;

    localparam logic [c_tw-1:0] c_long_last = c_tw'(LONG_CYC - 1);
    localparam logic [c_tw-1:0] c_dbl_last  = c_tw'(DBL_CYC - 1);
    localparam logic [c_tw-1:0] c_rpt_last  = c_tw'(RPT_CYC - 1);

    fsm_state_t      r_state;
    logic            r_kq;
    logic [c_tw-1:0] w_timer;
    logic            w_fall;
    logic            w_rise;
    logic            w_long_hit;
    logic            w_dbl_hit;
    logic            w_rpt_hit;
    logic            w_clear;
    logic            w_reload;
    logic            w_enable;

    assign w_fall     = ~key_state & r_kq;
    assign w_rise     = key_state & ~r_kq;
    assign w_long_hit = (w_timer == c_long_last);
    assign w_dbl_hit  = (w_timer == c_dbl_last);
    assign w_rpt_hit  = (w_timer == c_rpt_last);

    // Any key edge restarts the timer; leftover counts in IDLE are never read.
    assign w_clear  = w_fall | w_rise |
                      (((r_state == ST_PRESS1) || (r_state == ST_PRESS2)) && w_long_hit);
    assign w_reload = (r_state == ST_LONG) && w_rpt_hit;
    assign w_enable = (r_state != ST_IDLE);

    key_evt_timer #(
        .WIDTH (c_tw)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_clear),
        .i_enable     (w_enable),
        .i_reload     (w_reload),
        .i_reload_val ('0),
        .o_count      (w_timer)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_kq       <= 1'b1;
            pressed    <= 1'b0;
            busy       <= 1'b0;
            evt_single <= 1'b0;
            evt_double <= 1'b0;
            evt_long   <= 1'b0;
            evt_repeat <= 1'b0;
        end else begin
            r_kq       <= key_state;
            pressed    <= ~key_state;
            evt_single <= 1'b0;
            evt_double <= 1'b0;
            evt_long   <= 1'b0;
            evt_repeat <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state <= ST_PRESS1;
                        busy    <= 1'b1;
                    end
                end
                ST_PRESS1: begin
                    if (w_rise) begin
                        r_state <= ST_WAIT2;
                    end else if (w_long_hit) begin
                        r_state  <= ST_LONG;
                        evt_long <= 1'b1;
                    end
                end
                ST_WAIT2: begin
                    // Timeout wins over a coinciding fall, which then starts a fresh press.
                    if (w_dbl_hit) begin
                        evt_single <= 1'b1;
                        if (w_fall) begin
                            r_state <= ST_PRESS1;
                        end else begin
                            r_state <= ST_IDLE;
                            busy    <= 1'b0;
                        end
                    end else if (w_fall) begin
                        r_state <= ST_PRESS2;
                    end
                end
                ST_PRESS2: begin
                    if (w_rise) begin
                        r_state    <= ST_IDLE;
                        busy       <= 1'b0;
                        evt_double <= 1'b1;
                    end else if (w_long_hit) begin
                        r_state  <= ST_LONG;
                        evt_long <= 1'b1;
                    end
                end
                ST_LONG: begin
                    if (w_rise) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (w_rpt_hit) begin
                        evt_repeat <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_key_event.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_key_event : scenario and randomized checks of key_event against a timeline model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_key_event;

    localparam int unsigned LONG = 100;
    localparam int unsigned DBL  = 30;
    localparam int unsigned RPT  = 10;

    localparam int P_IDLE = 0, P_DOWN1 = 1, P_GAP = 2, P_DOWN2 = 3, P_HELD = 4;

    typedef struct {
        logic k;
        logic r;
        int   n;
    } seg_t;

    logic clk;
    logic rst;
    logic key_state;
    logic pressed, evt_single, evt_double, evt_long, evt_repeat, busy;
    logic [5:0] obs;

    assign obs = {pressed, busy, evt_single, evt_double, evt_long, evt_repeat};

    key_event #(
        .LONG_CYC (LONG),
        .DBL_CYC  (DBL),
        .RPT_CYC  (RPT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_state  (key_state),
        .pressed    (pressed),
        .evt_single (evt_single),
        .evt_double (evt_double),
        .evt_long   (evt_long),
        .evt_repeat (evt_repeat),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Timeline model: phase plus the edge index at which that phase began.
    int         m_phase = P_IDLE;
    int         m_n     = 0;
    int         m_t0    = 0;
    logic       m_kq    = 1'b1;
    logic [5:0] m_exp   = '0;

    seg_t segs[$];
    int   q_single[$], q_double[$], q_long[$], q_rpt[$], exp_q[$];
    int   seg_bad, first_bad_i, multi_bad;
    logic [5:0] bad_got, bad_exp;

    task automatic model_edge(input logic k, input logic r);
        int   age;
        logic fall, rise, e_s, e_d, e_l, e_r;
        m_n++;
        if (r) begin
            m_phase = P_IDLE;
            m_kq    = 1'b1;
            m_exp   = '0;
            return;
        end
        age  = m_n - m_t0;
        fall = !k && m_kq;
        rise = k && !m_kq;
        e_s = 0; e_d = 0; e_l = 0; e_r = 0;
        case (m_phase)
            P_IDLE:  if (fall) begin m_phase = P_DOWN1; m_t0 = m_n; end
            P_DOWN1: begin
                if (rise) begin m_phase = P_GAP; m_t0 = m_n; end
                else if (age == LONG) begin m_phase = P_HELD; m_t0 = m_n; e_l = 1; end
            end
            P_GAP: begin
                if (age == DBL) begin
                    e_s = 1;
                    if (fall) begin m_phase = P_DOWN1; m_t0 = m_n; end
                    else m_phase = P_IDLE;
                end else if (fall) begin m_phase = P_DOWN2; m_t0 = m_n; end
            end
            P_DOWN2: begin
                if (rise) begin m_phase = P_IDLE; e_d = 1; end
                else if (age == LONG) begin m_phase = P_HELD; m_t0 = m_n; e_l = 1; end
            end
            default: begin
                if (rise) m_phase = P_IDLE;
                else if (age > 0 && (age % RPT) == 0) e_r = 1;
            end
        endcase
        m_kq  = k;
        m_exp = {!k, m_phase != P_IDLE, e_s, e_d, e_l, e_r};
    endtask

    // Drive at the falling edge, let the DUT clock, observe at the next falling edge.
    task automatic step(input logic k, input logic r);
        key_state = k;
        rst       = r;
        @(posedge clk);
        model_edge(k, r);
        @(negedge clk);
    endtask

    // Event times are recorded as segment*1000 + cycle offset within that segment.
    task automatic play();
        seg_bad   = 0;
        multi_bad = 0;
        q_single.delete(); q_double.delete(); q_long.delete(); q_rpt.delete();
        foreach (segs[si]) begin
            for (int c = 0; c < segs[si].n; c++) begin
                step(segs[si].k, segs[si].r);
                if (obs !== m_exp) begin
                    if (seg_bad == 0) begin
                        first_bad_i = si * 1000 + c;
                        bad_got     = obs;
                        bad_exp     = m_exp;
                    end
                    seg_bad++;
                end
                if ($countones(obs[3:0]) > 1) multi_bad++;
                if (evt_single === 1'b1) q_single.push_back(si * 1000 + c);
                if (evt_double === 1'b1) q_double.push_back(si * 1000 + c);
                if (evt_long   === 1'b1) q_long.push_back(si * 1000 + c);
                if (evt_repeat === 1'b1) q_rpt.push_back(si * 1000 + c);
            end
        end
    endtask

    function automatic bit same_q(input int a[$], input int b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] != b[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic add_seg(input logic k, input int n);
        seg_t s;
        s.k = k; s.r = 1'b0; s.n = n;
        segs.push_back(s);
    endtask

    task automatic idle_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            n_cmp++;
            if (obs !== 6'b000000) begin
                n_err++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=000000", i, obs);
            end
        end
        step(1'b1, 1'b0);
        n_cmp++;
        if (obs !== 6'b000000) begin
            n_err++;
            $display("FAIL reset_idle got=%b exp=000000", obs);
        end
        step(1'b0, 1'b0);
        n_cmp++;
        if (obs !== 6'b110000) begin
            n_err++;
            $display("FAIL first_press got=%b exp=110000", obs);
        end
        step(1'b1, 1'b1);
        n_cmp++;
        if (obs !== 6'b000000) begin
            n_err++;
            $display("FAIL reset_busy got=%b exp=000000", obs);
        end
    endtask

    task automatic test_single();
        idle_reset();
        segs.delete();
        add_seg(1'b0, 10); add_seg(1'b1, 40);
        play();
        n_cmp++;
        if (seg_bad != 0) begin
            n_err++;
            $display("FAIL single_model at=%0d got=%b exp=%b", first_bad_i, bad_got, bad_exp);
        end
        exp_q = '{1030};
        n_cmp++;
        if (!same_q(q_single, exp_q) || q_double.size() + q_long.size() + q_rpt.size() != 0) begin
            n_err++;
            $display("FAIL single_time got=%p exp=%p others=%0d", q_single, exp_q,
                     q_double.size() + q_long.size() + q_rpt.size());
        end
    endtask

    task automatic test_double();
        idle_reset();
        segs.delete();
        add_seg(1'b0, 10); add_seg(1'b1, 10); add_seg(1'b0, 10); add_seg(1'b1, 40);
        play();
        n_cmp++;
        if (seg_bad != 0) begin
            n_err++;
            $display("FAIL double_model at=%0d got=%b exp=%b", first_bad_i, bad_got, bad_exp);
        end
        exp_q = '{3000};
        n_cmp++;
        if (!same_q(q_double, exp_q) || q_single.size() != 0) begin
            n_err++;
            $display("FAIL double_time got=%p exp=%p singles=%0d", q_double, exp_q, q_single.size());
        end
    endtask

    task automatic test_long();
        idle_reset();
        segs.delete();
        add_seg(1'b0, 135); add_seg(1'b1, 40);
        play();
        n_cmp++;
        if (seg_bad != 0) begin
            n_err++;
            $display("FAIL long_model at=%0d got=%b exp=%b", first_bad_i, bad_got, bad_exp);
        end
        exp_q = '{100};
        n_cmp++;
        if (!same_q(q_long, exp_q)) begin
            n_err++;
            $display("FAIL long_time got=%p exp=%p", q_long, exp_q);
        end
        exp_q = '{110, 120, 130};
        n_cmp++;
        if (!same_q(q_rpt, exp_q) || q_single.size() + q_double.size() != 0) begin
            n_err++;
            $display("FAIL long_repeat got=%p exp=%p", q_rpt, exp_q);
        end
    endtask

    task automatic test_gap_boundary();
        idle_reset();
        segs.delete();
        add_seg(1'b0, 10); add_seg(1'b1, 30); add_seg(1'b0, 5); add_seg(1'b1, 40);
        play();
        n_cmp++;
        if (seg_bad != 0) begin
            n_err++;
            $display("FAIL gap_model at=%0d got=%b exp=%b", first_bad_i, bad_got, bad_exp);
        end
        exp_q = '{2000, 3030};
        n_cmp++;
        if (!same_q(q_single, exp_q) || q_double.size() != 0) begin
            n_err++;
            $display("FAIL gap_single got=%p exp=%p doubles=%0d", q_single, exp_q, q_double.size());
        end
    endtask

    task automatic test_second_long();
        idle_reset();
        segs.delete();
        add_seg(1'b0, 10); add_seg(1'b1, 10); add_seg(1'b0, 135); add_seg(1'b1, 40);
        play();
        n_cmp++;
        if (seg_bad != 0) begin
            n_err++;
            $display("FAIL long2_model at=%0d got=%b exp=%b", first_bad_i, bad_got, bad_exp);
        end
        exp_q = '{2100};
        n_cmp++;
        if (!same_q(q_long, exp_q) || q_double.size() + q_single.size() != 0) begin
            n_err++;
            $display("FAIL long2_time got=%p exp=%p dbl=%0d", q_long, exp_q, q_double.size());
        end
        exp_q = '{2110, 2120, 2130};
        n_cmp++;
        if (!same_q(q_rpt, exp_q)) begin
            n_err++;
            $display("FAIL long2_repeat got=%p exp=%p", q_rpt, exp_q);
        end
    endtask

    task automatic test_reset_mid();
        idle_reset();
        segs.delete();
        add_seg(1'b0, 50);
        play();
        n_cmp++;
        if (seg_bad != 0 || q_long.size() + q_single.size() != 0) begin
            n_err++;
            $display("FAIL rstmid_pre at=%0d got=%b exp=%b", first_bad_i, bad_got, bad_exp);
        end
        step(1'b0, 1'b1);
        n_cmp++;
        if (obs !== 6'b000000) begin
            n_err++;
            $display("FAIL rstmid_outputs got=%b exp=000000", obs);
        end
        segs.delete();
        add_seg(1'b0, 115); add_seg(1'b1, 20);
        play();
        n_cmp++;
        if (seg_bad != 0) begin
            n_err++;
            $display("FAIL rstmid_model at=%0d got=%b exp=%b", first_bad_i, bad_got, bad_exp);
        end
        exp_q = '{100};
        n_cmp++;
        if (!same_q(q_long, exp_q) || q_single.size() + q_double.size() != 0) begin
            n_err++;
            $display("FAIL rstmid_long got=%p exp=%p", q_long, exp_q);
        end
    endtask

    task automatic test_random();
        seg_t s;
        int   n_evt;
        idle_reset();
        segs.delete();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                s.k = $urandom_range(0, 1); s.r = 1'b1; s.n = 1;
                segs.push_back(s);
            end
            add_seg(1'b0, $urandom_range(1, 140));
            add_seg(1'b1, $urandom_range(1, 45));
        end
        play();
        n_evt = q_single.size() + q_double.size() + q_long.size() + q_rpt.size();
        n_cmp++;
        if (seg_bad != 0) begin
            n_err++;
            $display("FAIL random_model bad=%0d at=%0d got=%b exp=%b",
                     seg_bad, first_bad_i, bad_got, bad_exp);
        end
        n_cmp++;
        if (multi_bad != 0) begin
            n_err++;
            $display("FAIL random_onehot got=%0d exp=0", multi_bad);
        end
        n_cmp++;
        if (n_evt == 0) begin
            n_err++;
            $display("FAIL random_activity got=%0d exp>0", n_evt);
        end
    endtask

    initial begin
        rst       = 1'b1;
        key_state = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_double();
        test_long();
        test_gap_boundary();
        test_second_long();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_event.md
KEY_EVENT -- requirements
Module: key_event

Interface
REQ-001 Parameter LONG_CYC, default 50_000_000, is the hold time in clocks (1 s at 50 MHz) before a long-press is declared.
REQ-002 Parameter DBL_CYC, default 15_000_000, is the maximum release gap in clocks (300 ms) for a second press to count as a double click.
REQ-003 Parameter RPT_CYC, default 5_000_000, is the auto-repeat period in clocks (100 ms) while a long press is held.
REQ-004 Port clk, input, 1 bit, is the single system clock.
REQ-005 Port rst, input, 1 bit, is the synchronous, active-high reset.
REQ-006 Port key_state, input, 1 bit, is the debounced key level from the debounce stage, already in the clk domain; 1 = released, 0 = pressed.
REQ-007 Port pressed, output, 1 bit, is the registered level of ~key_state.
REQ-008 Port evt_single, output, 1 bit, is a one-cycle pulse that flags a single click.
REQ-009 Port evt_double, output, 1 bit, is a one-cycle pulse that flags a double click.
REQ-010 Port evt_long, output, 1 bit, is a one-cycle pulse that flags the start of a long press.
REQ-011 Port evt_repeat, output, 1 bit, is a one-cycle pulse that flags an auto-repeat tick during a long press.
REQ-012 Port busy, output, 1 bit, is high whenever the FSM is not in IDLE.

Function
REQ-013 The block SHALL register key_state into k_q each cycle; a fall is key_state=0 with k_q=1, and a rise is key_state=1 with k_q=0.
REQ-014 All outputs SHALL be registered, so each event pulse appears in the cycle after its triggering condition is evaluated.
REQ-015 The FSM SHALL have the states IDLE, PRESS1, WAIT2, PRESS2 and LONG.
REQ-016 In IDLE, a fall SHALL move the FSM to PRESS1 and clear the timer.
REQ-017 In PRESS1, a rise SHALL move the FSM to WAIT2 and clear the timer; if the timer reaches LONG_CYC-1 while the key is pressed, the block SHALL move to LONG, pulse evt_long and clear the timer.
REQ-018 In WAIT2, a fall with timer < DBL_CYC-1 SHALL move the FSM to PRESS2 and clear the timer; timer = DBL_CYC-1 SHALL pulse evt_single and move the FSM to IDLE.
REQ-019 In WAIT2, a fall in the same cycle as timer = DBL_CYC-1 SHALL resolve as single: pulse evt_single, then treat the fall as a new press and go to PRESS1.
REQ-020 In PRESS2, a rise SHALL pulse evt_double and move the FSM to IDLE; timer = LONG_CYC-1 SHALL pulse evt_long, discard the double and move the FSM to LONG.
REQ-021 In LONG, the block SHALL pulse evt_repeat each time the timer reaches RPT_CYC-1 and reload the timer to 0; a rise SHALL move the FSM to IDLE with no further event.
REQ-022 The timer SHALL be clog2(max(LONG_CYC, DBL_CYC, RPT_CYC)) bits wide, SHALL count up by 1 per cycle outside IDLE, and SHALL saturate rather than wrap.
REQ-023 At most one event output SHALL be high in any cycle.

Reset
REQ-024 While rst=1 on a clock edge, the block SHALL set state=IDLE, timer=0 and k_q=1, and SHALL drive every output to 0.
REQ-025 Reset asserted mid-operation SHALL discard the pending event, and no event SHALL be emitted for it.
REQ-026 A key held through reset release SHALL be detected as a fall on the first post-reset cycle.

Structure
REQ-027 A shared definitions package key_pkg SHALL hold the state encoding and the default timing constants, so the debounce stage and key_event share the 50 MHz figures.
REQ-028 The timer SHALL be one sub-module, key_evt_timer, with clear, enable, reload and saturating count; edge detection and the FSM SHALL stay in key_event.

Verification (LONG_CYC=100, DBL_CYC=30, RPT_CYC=10; cycle 0 = the cycle the edge is detected)
REQ-029 Press 10 cycles, then release and stay idle -> exactly one evt_single at release+30, and no other pulses.
REQ-030 Press 10, release 10, press 10, release -> evt_double one cycle after the second release, and no evt_single.
REQ-031 Hold the key for 135 cycles -> evt_long at press+100, evt_repeat at +110, +120 and +130, and nothing on release.
REQ-032 Release gap ending exactly at timer = 29 -> evt_single fires, and the coinciding fall enters PRESS1 (busy stays 1).
REQ-033 Second press held for 100 cycles -> evt_long, then repeats, and never evt_double.
REQ-034 rst pulsed at press+50 while the key is held -> all outputs are 0 the next cycle with no event; after reset the held key restarts PRESS1, and evt_long fires 100 cycles after reset release.
